// File: rtl/shift_arb_ctrl.sv
// Round-robin arbiter and 1-cycle right-shift sequencer for the shared mantissa shifter.
// Optional sticky-bit logic is built only when SHIFT_ARB_STICKY_EN is defined.
module shift_arb_ctrl #(
   parameter int MW = 24,
   parameter int SW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [MW-1:0] req0_mant,
   input  logic [SW-1:0] req0_nshift,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [MW-1:0] req1_mant,
   input  logic [SW-1:0] req1_nshift,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [MW-1:0] resp_data,
   output logic          resp_sticky,
   output logic          resp_id,
   output logic          busy
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both
   // high. reqN_ready is only ever raised alongside reqN_valid. resp_* are held
   // stable while resp_valid && !resp_ready.
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e          state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic [MW-1:0]   data_q, data_d;
   logic            sticky_q, sticky_d;
   logic            id_q, id_d;

   logic            can_accept;
   logic            gnt0, gnt1;
   logic [MW-1:0]   sel_mant;
   logic [SW-1:0]   sel_nshift;
   logic [MW-1:0]   shifted;

   always_comb begin
      can_accept = (state_q == EMPTY) || resp_ready;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      if (!rst && can_accept) begin
         if (req0_valid && req1_valid) begin
            // Tie goes to whoever did not win last time.
            gnt0 = last_grant_q;
            gnt1 = ~last_grant_q;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign sel_mant   = gnt1 ? req1_mant   : req0_mant;
   assign sel_nshift = gnt1 ? req1_nshift : req0_nshift;
   assign shifted    = sel_mant >> sel_nshift;

`ifdef SHIFT_ARB_STICKY_EN
   logic [MW-1:0] lost_mask;
   // Ones over the bits shifted out; the left shift saturates to zero for
   // amounts >= MW, so the mask then covers the whole mantissa.
   assign lost_mask = ~({MW{1'b1}} << sel_nshift);
   assign sticky_d  = |(sel_mant & lost_mask);
`else
   assign sticky_d  = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      data_d       = data_q;
      id_d         = id_q;
      if (gnt0 || gnt1) begin
         state_d      = FULL;
         last_grant_d = gnt1;
         data_d       = shifted;
         id_d         = gnt1;
      end else if (state_q == FULL && resp_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= EMPTY;
         last_grant_q <= 1'b0;
         data_q       <= '0;
         sticky_q     <= 1'b0;
         id_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         data_q       <= data_d;
         id_q         <= id_d;
         if (gnt0 || gnt1) begin
            sticky_q <= sticky_d;
         end
      end
   end

   assign req0_ready  = gnt0;
   assign req1_ready  = gnt1;
   assign resp_valid  = (state_q == FULL);
   assign busy        = (state_q == FULL);
   assign resp_data   = data_q;
   assign resp_sticky = sticky_q;
   assign resp_id     = id_q;

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Self-checking bench for shift_arb_ctrl: reference arbiter/shift model feeding an
// expected-result queue. Honours SHIFT_ARB_STICKY_EN for the sticky expectation.
module tb_shift_arb_ctrl;
   localparam int MW = 24;
   localparam int SW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid = 1'b0;
   logic          req0_ready;
   logic [MW-1:0] req0_mant = '0;
   logic [SW-1:0] req0_nshift = '0;
   logic          req1_valid = 1'b0;
   logic          req1_ready;
   logic [MW-1:0] req1_mant = '0;
   logic [SW-1:0] req1_nshift = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [MW-1:0] resp_data;
   logic          resp_sticky;
   logic          resp_id;
   logic          busy;

   shift_arb_ctrl #(.MW(MW), .SW(SW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_mant   (req0_mant),
      .req0_nshift (req0_nshift),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_mant   (req1_mant),
      .req1_nshift (req1_nshift),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_data   (resp_data),
      .resp_sticky (resp_sticky),
      .resp_id     (resp_id),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int               n_checks = 0;
   int               n_fail   = 0;
   logic [MW+1:0]    exp_q[$];
   logic             m_full     = 1'b0;
   logic             m_last     = 1'b0;
   logic             m_post_rst = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Packs {id, sticky, data}; bitwise walk rather than a shift operator.
   function automatic logic [MW+1:0] model(input logic id, input logic [MW-1:0] m,
                                           input logic [SW-1:0] ns);
      logic [MW-1:0] d;
      logic          s;
      d = '0;
      s = 1'b0;
      for (int i = 0; i < MW; i++) begin
         int j;
         j = i + int'(ns);
         if (j < MW) d[i] = m[j];
         if (i < int'(ns)) s = s | m[i];
      end
`ifndef SHIFT_ARB_STICKY_EN
      s = 1'b0;
`endif
      return {id, s, d};
   endfunction

   task automatic cycle(input logic r,
                        input logic v0, input logic [MW-1:0] m0, input logic [SW-1:0] s0,
                        input logic v1, input logic [MW-1:0] m1, input logic [SW-1:0] s1,
                        input logic rr);
      logic          e0, e1, can;
      logic [MW+1:0] got;
      @(negedge clk);
      rst = r;
      req0_valid = v0; req0_mant = m0; req0_nshift = s0;
      req1_valid = v1; req1_mant = m1; req1_nshift = s1;
      resp_ready = rr;
      #1;
      e0  = 1'b0;
      e1  = 1'b0;
      can = !m_full || rr;
      if (!r && can) begin
         if (v0 && v1) begin
            e1 = !m_last;
            e0 = m_last;
         end else begin
            e0 = v0;
            e1 = v1;
         end
      end
      check("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
      check("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
      check("resp_valid", {31'd0, resp_valid}, {31'd0, m_full});
      check("busy", {31'd0, busy}, {31'd0, m_full});
      got = {resp_id, resp_sticky, resp_data};
      if (m_post_rst) check("reset_resp", 32'(got), 32'd0);
      if (m_full) begin
         if (exp_q.size() == 0) begin
            check("exp_q_size", 32'(exp_q.size()), 32'd1);
         end else begin
            check("resp", 32'(got), 32'(exp_q[0]));
            if (rr && !r) void'(exp_q.pop_front());
         end
      end
      if (!r && (e0 || e1)) exp_q.push_back(model(e1, e1 ? m1 : m0, e1 ? s1 : s0));
      @(posedge clk);
      if (r) begin
         m_full = 1'b0;
         m_last = 1'b0;
         exp_q.delete();
         m_post_rst = 1'b1;
      end else begin
         m_post_rst = 1'b0;
         if (e0 || e1) begin
            m_full = 1'b1;
            m_last = e1;
         end else if (rr) begin
            m_full = 1'b0;
         end
      end
   endtask

   task automatic idle(input logic rr);
      cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, rr);
   endtask

   initial begin
      logic [MW-1:0] ma, mb;
      // Reset and first single-requester transfers
      cycle(1'b1, 1'b1, 24'h123456, 5'd3, 1'b1, 24'h654321, 5'd2, 1'b1);
      cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      cycle(1'b0, 1'b1, 24'h800000, 5'd4, 1'b0, '0, '0, 1'b1);
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 24'hFFFFFF, 5'd8, 1'b1);
      idle(1'b1);
      idle(1'b1);
      // Back-to-back ties alternate from a fresh reset
      cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         ma = 24'($urandom());
         mb = 24'($urandom());
         cycle(1'b0, 1'b1, ma, 5'($urandom_range(0, 31)), 1'b1, mb, 5'($urandom_range(0, 31)), 1'b1);
      end
      // Backpressure hold with both requesters pending
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 1'b1, 24'hA5A5A5, 5'd1, 1'b1, 24'h5A5A5A, 5'd2, 1'b0);
      cycle(1'b0, 1'b1, 24'hA5A5A5, 5'd1, 1'b1, 24'h5A5A5A, 5'd2, 1'b1);
      idle(1'b1);
      idle(1'b1);
      // Shift boundaries
      cycle(1'b0, 1'b1, 24'h000001, 5'd31, 1'b0, '0, '0, 1'b1);
      cycle(1'b0, 1'b1, 24'hABCDEF, 5'd0, 1'b0, '0, '0, 1'b1);
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 24'hFFFFFF, 5'd24, 1'b1);
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 24'h800001, 5'd23, 1'b1);
      idle(1'b1);
      // Reset while a result is held, then first tie goes to requester 1
      cycle(1'b0, 1'b1, 24'h00F000, 5'd12, 1'b0, '0, '0, 1'b0);
      cycle(1'b0, 1'b1, 24'h111111, 5'd1, 1'b1, 24'h222222, 5'd1, 1'b0);
      cycle(1'b1, 1'b1, 24'h111111, 5'd1, 1'b1, 24'h222222, 5'd1, 1'b0);
      cycle(1'b0, 1'b1, 24'h333333, 5'd2, 1'b1, 24'h444444, 5'd3, 1'b1);
      cycle(1'b0, 1'b1, 24'h555555, 5'd4, 1'b1, 24'h666666, 5'd5, 1'b1);
      idle(1'b1);
      // Random traffic with backpressure and occasional reset
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 63) == 0,
               1'($urandom_range(0, 1)), 24'($urandom()), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 24'($urandom()), 5'($urandom_range(0, 31)),
               $urandom_range(0, 3) != 0);
      end
      idle(1'b1);
      idle(1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_arb_ctrl.md
Name: shift_arb_ctrl

Overview:
- Two-requester arbiter and sequencer for the single shared 24-bit mantissa right-shift datapath in the multiply/Nroot unit.
- Requesters: port 0 = exponent-alignment path, port 1 = Nroot normalisation path.
- Grants one request per cycle, round-robin. Performs the logical right shift and registers the result with a requester tag and sticky bit.
- Holds the result under a valid/ready handshake until the consumer accepts it.

Parameters:
- MW, 24, mantissa width in bits.
- SW, 5, shift-amount width; shift range 0..(2^SW-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a shift request.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_mant  input  MW  requester 0 mantissa.
- req0_nshift  input  SW  requester 0 shift amount.
- req1_valid  input  1  requester 1 has a shift request.
- req1_ready  output  1  requester 1 request accepted this cycle.
- req1_mant  input  MW  requester 1 mantissa.
- req1_nshift  input  SW  requester 1 shift amount.
- resp_valid  output  1  result register holds a valid result.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  MW  shifted mantissa.
- resp_sticky  output  1  OR of all bits shifted out.
- resp_id  output  1  requester that owns the result.
- busy  output  1  result register occupied (equals resp_valid).

Behaviour:
- Reset: the following are 0 in the cycle after rst is sampled high: resp_valid, resp_data, resp_sticky, resp_id, busy, last_grant register. rst dominates all other inputs. Any held result is discarded; no ready pulses are issued in a reset cycle.
- States: EMPTY (result register free) and FULL (result held).
- can_accept = EMPTY, or (FULL and resp_ready).
- Grant is evaluated combinationally each cycle, only when can_accept:
  - Only one valid request: that requester wins.
  - Both valid: the requester not equal to last_grant wins. After reset, last_grant=0, so requester 1 wins the first tie.
  - req0_ready and req1_ready are one-hot or zero. A ready is never asserted without the matching valid.
- Accept (valid & ready) at edge N: at edge N+1, resp_data = mant >> nshift (logical, zero-fill from MSB, including bit MW-1), resp_sticky = OR of mant[nshift-1:0] (0 when nshift=0), resp_id = winner, resp_valid = 1, last_grant = winner. Latency is exactly 1 cycle.
- Shift amounts >= MW: resp_data = 0, resp_sticky = OR of all of mant.
- Transitions:
  - EMPTY, no grant: stay EMPTY.
  - EMPTY, grant: go to FULL.
  - FULL, resp_ready=0: hold. resp_data, resp_sticky and resp_id are stable and no grants are issued.
  - FULL, resp_ready=1, grant: stay FULL and load the new result (back-to-back throughput of 1 per cycle).
  - FULL, resp_ready=1, no grant: go to EMPTY. resp_data, resp_sticky and resp_id keep their last values.
- Requesters may drop valid or change data while ready is low. The controller samples mant/nshift only on the accept edge.
- No combinational path from resp_ready to resp_* outputs. req*_ready depends combinationally on req*_valid, resp_ready and state only.

Optional Feature:
- Macro: SHIFT_ARB_STICKY_EN.
- Defined: resp_sticky is computed as above.
- Undefined: the sticky logic is not built and resp_sticky is constant 0. All other behaviour and timing are unchanged.

Test Plan:
- Reset, then req0_valid=1, mant=24'h800000, nshift=5'd4, resp_ready=1 -> req0_ready=1. Next cycle: resp_valid=1, resp_data=24'h080000, resp_sticky=0, resp_id=0.
- req1 only, mant=24'hFFFFFF, nshift=5'd8 -> resp_data=24'h00FFFF, resp_sticky=1 (sticky=0 if macro undefined), resp_id=1.
- Both valid every cycle, resp_ready=1, starting from reset -> grants alternate 1,0,1,0. resp_valid stays high every cycle; resp_id follows the grant one cycle later.
- resp_ready=0 with result held and both requesters valid for 3 cycles -> no req*_ready. resp_data/resp_id stable. The first grant occurs in the cycle resp_ready rises, and the result is replaced at the next edge.
- nshift=5'd31, mant=24'h000001 -> resp_data=0, resp_sticky=1. nshift=0, mant=24'hABCDEF -> resp_data=24'hABCDEF, resp_sticky=0.
- rst asserted while FULL and resp_ready=0 -> next cycle resp_valid=0, ready outputs 0 during reset. The first tie after release grants requester 1.
